// File: rtl/q_func_sequencer.sv
// q_func_sequencer: valid/ready request/response sequencer wrapped around user_logic (q_func).
// Accepts one (X, N, T) operand set per input handshake and drives it to user_logic.
// Waits a fixed LATENCY, captures Q, then presents it on a valid/ready output channel.
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready          operand handshake; in_x/in_n/in_t are the operands
//   qf_x/qf_n/qf_t             registered operands to user_logic X/N/T
//   qf_q                       user_logic Q result
//   out_valid/out_ready/out_q  result handshake and captured result
//   busy                       high while an operation is in flight or held
//   done_count                 number of consumed results (wraps silently)
module q_func_sequencer #(
    parameter int W       = 32,
    parameter int LATENCY = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_x,
    input  logic [W-1:0]     in_n,
    input  logic [W-1:0]     in_t,
    output logic [W-1:0]     qf_x,
    output logic [W-1:0]     qf_n,
    output logic [W-1:0]     qf_t,
    input  logic [W-1:0]     qf_q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_q,
    output logic             busy,
    output logic [CNT_W-1:0] done_count
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, HOLD = 2'd2} state_t;
    state_t     state, state_next;
    logic [7:0] cnt;
    logic       accept;
    assign accept = in_valid & in_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = WAIT;
            WAIT:    if (cnt == 8'd0) state_next = HOLD;
            HOLD:    if (out_ready) state_next = in_valid ? WAIT : IDLE;
            default: state_next = IDLE;
        endcase
    end
    // out_valid is exactly "in HOLD": it rises on the capture edge and falls on the handshake edge.
    always_comb begin
        in_ready  = (state == IDLE) || (state == HOLD && out_ready);
        out_valid = (state == HOLD);
        busy      = (state != IDLE);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qf_x       <= '0;
            qf_n       <= '0;
            qf_t       <= '0;
            cnt        <= 8'd0;
            out_q      <= '0;
            done_count <= '0;
        end else begin
            if (accept) begin
                qf_x <= in_x;
                qf_n <= in_n;
                qf_t <= in_t;
                cnt  <= 8'(LATENCY - 1);
            end else if (state == WAIT && cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end
            if (state == WAIT && cnt == 8'd0) out_q <= qf_q;
            if (state == HOLD && out_ready) done_count <= done_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_q_func_sequencer.sv
// tb_q_func_sequencer: randomized self-checking bench for q_func_sequencer with a delayed XOR q_func model.
module tb_q_func_sequencer;
    localparam int W = 32;
    localparam int LAT = 8;
    localparam int CW = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [W-1:0] in_x = '0, in_n = '0, in_t = '0;
    logic [W-1:0] qf_x, qf_n, qf_t, qf_q;
    logic out_valid;
    logic out_ready = 1'b0;
    logic [W-1:0] out_q;
    logic busy;
    logic [CW-1:0] done_count;
    int vectors = 0;
    int miscompares = 0;
    int exp_done = 0;
    always #5 clk = ~clk;
    q_func_sequencer #(.W(W), .LATENCY(LAT), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_n(in_n), .in_t(in_t), .qf_x(qf_x), .qf_n(qf_n), .qf_t(qf_t),
        .qf_q(qf_q), .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q),
        .busy(busy), .done_count(done_count)
    );
    // user_logic stand-in: Q = X^N^T, valid LAT cycles after the operands change
    logic [W-1:0] pipe [LAT-1];
    always @(posedge clk) begin
        pipe[0] <= qf_x ^ qf_n ^ qf_t;
        for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
    end
    assign qf_q = pipe[LAT-2];
    task automatic step();
        @(negedge clk);
    endtask
    // counts cycles until out_valid is seen, bounded so a stuck DUT still ends
    task automatic wait_result(input int start, output int lat);
        lat = start;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask
    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] n, input logic [W-1:0] t);
        in_valid = 1'b1;
        in_x = x;
        in_n = n;
        in_t = t;
        step();
        in_valid = 1'b0;
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        step();
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done_count !== 4'd0 || qf_x !== 32'd0 || out_q !== 32'd0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset: ov=%b busy=%b dc=%0d qf_x=%h out_q=%h rdy=%b, want 0 0 0 0 0 1",
                     out_valid, busy, done_count, qf_x, out_q, in_ready);
        end
        rst_n = 1'b1;
        step();
        exp_done = 0;
    endtask
    task automatic test_single();
        int lat;
        bit wait_rdy_bad = 0;
        launch(32'h10, 32'h3, 32'h100);
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready !== 1'b0) wait_rdy_bad = 1;
            step();
            lat++;
        end
        vectors++;
        if (lat != LAT || out_q !== 32'h113 || wait_rdy_bad) begin
            miscompares++;
            $display("FAIL single: lat=%0d out_q=%h wait_rdy_high=%0d, want lat=%0d out_q=00000113 0",
                     lat, out_q, wait_rdy_bad, LAT);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_done = (exp_done + 1) % 16;
        vectors++;
        if (done_count !== 4'(exp_done) || busy !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_done: dc=%0d busy=%b ov=%b, want %0d 0 0", done_count, busy, out_valid, exp_done);
        end
    endtask
    task automatic test_back_to_back();
        logic [W-1:0] ox[4], on[4], ot[4];
        int idx = 0, r = 0, e = 0;
        bit acc;
        for (int i = 0; i < 4; i++) begin
            ox[i] = $urandom; on[i] = $urandom; ot[i] = $urandom;
        end
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_x = ox[0]; in_n = on[0]; in_t = ot[0];
        while (r < 4 && e < 60) begin
            acc = in_valid && in_ready;
            if (out_valid && out_ready) exp_done = (exp_done + 1) % 16;
            step();
            if (acc) begin
                idx++;
                if (idx < 4) begin
                    in_x = ox[idx]; in_n = on[idx]; in_t = ot[idx];
                end else in_valid = 1'b0;
            end
            if (e > 0 && out_valid) begin
                vectors++;
                if (e != LAT + (LAT + 1) * r || out_q !== (ox[r] ^ on[r] ^ ot[r]) || in_ready !== 1'b1 || qf_x !== ox[r]) begin
                    miscompares++;
                    $display("FAIL b2b[%0d]: cycle=%0d out_q=%h rdy=%b qf_x=%h, want cycle=%0d out_q=%h rdy=1 qf_x=%h",
                             r, e, out_q, in_ready, qf_x, LAT + (LAT + 1) * r, ox[r] ^ on[r] ^ ot[r], ox[r]);
                end
                r++;
            end
            e++;
        end
        step();
        exp_done = (exp_done + 1) % 16;
        out_ready = 1'b0;
        in_valid = 1'b0;
        vectors++;
        if (r != 4 || done_count !== 4'(exp_done) || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_count: results=%0d dc=%0d busy=%b, want 4 %0d 0", r, done_count, busy, exp_done);
        end
    endtask
    task automatic test_backpressure();
        logic [W-1:0] x = $urandom, n = $urandom, t = $urandom;
        int lat;
        launch(x, n, t);
        wait_result(0, lat);
        in_valid = 1'b1;
        in_x = ~x; in_n = ~n; in_t = ~t;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_q !== (x ^ n ^ t) || in_ready !== 1'b0 || qf_x !== x || qf_n !== n || qf_t !== t) begin
                miscompares++;
                $display("FAIL backpressure[%0d]: ov=%b out_q=%h rdy=%b qf_x=%h, want 1 %h 0 %h", i, out_valid, out_q, in_ready, qf_x, x ^ n ^ t, x);
            end
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_done = (exp_done + 1) % 16;
        vectors++;
        if (done_count !== 4'(exp_done) || out_valid !== 1'b0 || qf_x !== x) begin
            miscompares++;
            $display("FAIL backpressure_release: dc=%0d ov=%b qf_x=%h, want %0d 0 %h", done_count, out_valid, qf_x, exp_done, x);
        end
    endtask
    task automatic test_wait_input();
        logic [W-1:0] x = $urandom, n = $urandom, t = $urandom;
        int lat;
        launch(x, n, t);
        step(); step();
        in_valid = 1'b1;
        in_x = 32'hDEAD;
        step();
        in_valid = 1'b0;
        vectors++;
        if (qf_x !== x) begin
            miscompares++;
            $display("FAIL wait_input_qf: qf_x=%h, want %h", qf_x, x);
        end
        wait_result(3, lat);
        vectors++;
        if (lat != LAT || out_q !== (x ^ n ^ t) || qf_x !== x) begin
            miscompares++;
            $display("FAIL wait_input_result: lat=%0d out_q=%h qf_x=%h, want %0d %h %h", lat, out_q, qf_x, LAT, x ^ n ^ t, x);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_done = (exp_done + 1) % 16;
    endtask
    task automatic test_reset_mid();
        logic [W-1:0] x = $urandom | 32'h1, n = $urandom, t = $urandom;
        int lat;
        launch(x, n, t);
        step(); step(); step();
        rst_n = 1'b0;
        #1;
        exp_done = 0;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done_count !== 4'd0 || qf_x !== 32'd0 || qf_n !== 32'd0 || qf_t !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_mid: ov=%b busy=%b dc=%0d qf_x=%h qf_n=%h qf_t=%h, want all 0",
                     out_valid, busy, done_count, qf_x, qf_n, qf_t);
        end
        step();
        rst_n = 1'b1;
        step();
        x = $urandom; n = $urandom; t = $urandom;
        launch(x, n, t);
        wait_result(0, lat);
        vectors++;
        if (lat != LAT || out_q !== (x ^ n ^ t)) begin
            miscompares++;
            $display("FAIL reset_mid_after: lat=%0d out_q=%h, want %0d %h", lat, out_q, LAT, x ^ n ^ t);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_done = (exp_done + 1) % 16;
    endtask
    task automatic test_counter_wrap();
        logic [W-1:0] x, n, t;
        int lat;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        exp_done = 0;
        for (int i = 1; i <= 17; i++) begin
            x = $urandom; n = $urandom; t = $urandom;
            launch(x, n, t);
            wait_result(0, lat);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            exp_done = (exp_done + 1) % 16;
            vectors++;
            if (out_q !== (x ^ n ^ t) || done_count !== 4'(exp_done)) begin
                miscompares++;
                $display("FAIL wrap[%0d]: out_q=%h dc=%0d, want %h %0d", i, out_q, done_count, x ^ n ^ t, exp_done);
            end
        end
    endtask
    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_wait_input();
        test_reset_mid();
        test_counter_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/q_func_sequencer.md
Name: q_func_sequencer

Overview:
- Request/response sequencer placed directly upstream of user_logic (the q_func wrapper).
- Accepts one (X, N, T) operand set per valid/ready handshake and drives it to user_logic's X/N/T inputs.
- Holds those operands stable for a fixed compute latency, then samples user_logic's Q output.
- Presents Q on a valid/ready output channel to the PS-side register/AXI glue.

Parameters:
- W, 32, operand and result width (matches user_logic X/N/T/Q).
- LATENCY, 8, cycles from operand launch to a valid Q at user_logic output; legal range 1..255.
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  sequencer can accept an operand set.
- in_x  in  W  X operand.
- in_n  in  W  N operand.
- in_t  in  W  T operand.
- qf_x  out  W  registered X to user_logic.X.
- qf_n  out  W  registered N to user_logic.N.
- qf_t  out  W  registered T to user_logic.T.
- qf_q  in  W  user_logic.Q (fixed-point result).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_q  out  W  captured result.
- busy  out  1  high in WAIT or HOLD.
- done_count  out  CNT_W  number of results consumed.

Behaviour:
- Clock and reset: one clock, clk; rst_n is asynchronous, active-low.
- Reset values: state=IDLE; qf_x/qf_n/qf_t=0; out_q=0; out_valid=0; busy=0; done_count=0; latency counter=0.
- States:
  - IDLE: no operation in flight.
  - WAIT: operands launched, latency counter running.
  - HOLD: result held on output.
- in_ready (combinational): 1 when state==IDLE, or when state==HOLD and out_ready==1. It is 0 in WAIT.
- Accept: when in_valid & in_ready at edge k:
  - qf_* <= in_*.
  - counter <= LATENCY-1.
  - state <= WAIT.
- WAIT:
  - When counter != 0, counter decrements each edge.
  - When counter==0 at edge k+LATENCY: out_q <= qf_q, out_valid <= 1, state <= HOLD.
  - out_valid therefore rises exactly LATENCY cycles after acceptance.
- Operand stability: qf_* change only on an accept edge. They remain stable through WAIT and HOLD and are not cleared afterwards.
- Input ignored in WAIT: in_valid is ignored because in_ready=0. No operands are latched and there is no side effect.
- HOLD:
  - out_valid=1 and out_q stable until out_valid & out_ready.
  - On that handshake, done_count increments.
  - If in_valid is also high on the same edge, the new operands are accepted and the next state is WAIT; out_valid falls on that edge.
  - Otherwise the next state is IDLE and out_valid <= 0.
- Throughput: with continuous in_valid and out_ready, one result every LATENCY+1 cycles.
- done_count wraps from 2^CNT_W-1 to 0 with no flag.
- busy = (state != IDLE).
- Reset mid-operation (asserting rst_n low in WAIT or HOLD): all state returns to reset values immediately. The in-flight result is discarded and done_count is cleared.
- LATENCY=1: the counter loads 0; capture happens on the edge after acceptance.
- No arithmetic is performed on data. out_q is a bit-exact copy of qf_q sampled at the capture edge.

Test Plan:
- Single transaction (LATENCY=8, bench model of q_func with Q = X^N^T after 8 cycles):
  - Stimulus: X=0x10, N=0x3, T=0x100 accepted at cycle 0.
  - Response: out_valid rises at cycle 8 with out_q=0x113; done_count=1 after the out handshake; busy low afterwards.
- Back-to-back:
  - Stimulus: 4 operand sets with in_valid and out_ready held high.
  - Response: results appear in order at cycles 8, 17, 26, 35. in_ready is high on each HOLD-handshake edge. done_count=4.
- Backpressure:
  - Stimulus: out_ready held low for 5 cycles after out_valid rises.
  - Response: out_q is stable, in_ready=0, and qf_* are unchanged for those 5 cycles. The handshake occurs on the 6th cycle.
- Input during WAIT:
  - Stimulus: in_valid pulsed with X=0xDEAD at cycle 3 of WAIT.
  - Response: not accepted; qf_x keeps its original value; the result matches the original operands.
- Reset mid-WAIT:
  - Stimulus: rst_n low at cycle 4 after acceptance.
  - Response: out_valid=0, qf_*=0, busy=0, and done_count=0 immediately. After release, a new transaction completes normally with 8-cycle latency.
- Counter wrap (CNT_W=4):
  - Stimulus: 17 completed transactions.
  - Response: done_count reads 15 after the 15th, 0 after the 16th, and 1 after the 17th.
